// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: word-addressed storage with a fixed access
// latency, a core-freezing stall, and rejection of misaligned requests.
module dmem_ctrl #(
    parameter int N     = 64,
    parameter int DEPTH = 32,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         stall,
    output logic         misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] r_idx;
    logic [N-1:0]  r_wdata;
    logic          r_wr;
    logic [N-1:0]  r_rdata;
    logic          r_mis;
    logic [N-1:0]  r_mem [DEPTH];

    logic          w_req;
    logic          w_aligned;
    logic          w_accept;
    logic          w_commit;
    logic          w_unused_addr;

    assign w_req         = DM_readEnable | DM_writeEnable;
    assign w_aligned     = (DM_addr[2:0] == 3'b000);
    assign w_accept      = (r_state == IDLE) & w_req & w_aligned;
    assign w_commit      = (r_state == BUSY) & (r_cnt == {CW{1'b0}});
    // High address bits are deliberately dropped so accesses wrap modulo DEPTH.
    assign w_unused_addr = ^DM_addr[N-1:AW+3];

    // Gated by reset so the core is released the instant reset asserts.
    assign stall       = reset & (w_accept | (r_state == BUSY));
    assign DM_readData = r_rdata;
    assign misaligned  = r_mis;

    // Next-state and latency-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CW'(LAT - 1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state, request latches, read data and misaligned pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
            r_idx   <= {AW{1'b0}};
            r_wdata <= {N{1'b0}};
            r_wr    <= 1'b0;
            r_rdata <= {N{1'b0}};
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mis   <= (r_state == IDLE) & w_req & ~w_aligned;
            if (w_accept) begin
                r_idx   <= DM_addr[AW+2:3];
                r_wdata <= DM_writeData;
                r_wr    <= DM_writeEnable;
            end
            if (w_commit && !r_wr) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Storage array; cleared on reset so a pending write is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {N{1'b0}};
            end
        end else if (w_commit && r_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (LAT 2, 1, 4) checked each cycle against a
// transaction-level model, plus directed literal expectations.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic [63:0] rdata [3];
    logic        we    [3];
    logic        re    [3];
    logic        stall_o [3];
    logic        mis_o   [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    localparam int LATS [3] = '{2, 1, 4};

    always #5 clk = ~clk;

    dmem_ctrl #(.N(64), .DEPTH(32), .LAT(2)) u0 (
        .clk(clk), .reset(reset), .DM_addr(addr[0]), .DM_writeData(wdata[0]),
        .DM_writeEnable(we[0]), .DM_readEnable(re[0]), .DM_readData(rdata[0]),
        .stall(stall_o[0]), .misaligned(mis_o[0]));
    dmem_ctrl #(.N(64), .DEPTH(32), .LAT(1)) u1 (
        .clk(clk), .reset(reset), .DM_addr(addr[1]), .DM_writeData(wdata[1]),
        .DM_writeEnable(we[1]), .DM_readEnable(re[1]), .DM_readData(rdata[1]),
        .stall(stall_o[1]), .misaligned(mis_o[1]));
    dmem_ctrl #(.N(64), .DEPTH(32), .LAT(4)) u2 (
        .clk(clk), .reset(reset), .DM_addr(addr[2]), .DM_writeData(wdata[2]),
        .DM_writeEnable(we[2]), .DM_readEnable(re[2]), .DM_readData(rdata[2]),
        .stall(stall_o[2]), .misaligned(mis_o[2]));

    // Model: an access accepted in cycle acc_t stalls through acc_t+LAT,
    // commits on the edge ending acc_t+LAT and spends acc_t+LAT+1 in DONE.
    int          acc_t [3];
    logic [63:0] mm    [3][32];
    logic [63:0] m_rd  [3];
    logic        m_mis [3];
    logic [4:0]  l_idx [3];
    logic [63:0] l_d   [3];
    logic        l_w   [3];

    task automatic m_clear();
        for (int k = 0; k < 3; k++) begin
            acc_t[k] = -1;
            m_rd[k]  = 64'd0;
            m_mis[k] = 1'b0;
            l_idx[k] = 5'd0;
            l_d[k]   = 64'd0;
            l_w[k]   = 1'b0;
            for (int j = 0; j < 32; j++) mm[k][j] = 64'd0;
        end
    endtask

    function automatic bit m_idle(int k, int c);
        return (acc_t[k] < 0) || (c > acc_t[k] + LATS[k] + 1);
    endfunction

    function automatic bit m_busy(int k, int c);
        return (acc_t[k] >= 0) && (c > acc_t[k]) && (c <= acc_t[k] + LATS[k]);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear();
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit req;
                bit al;
                req = we[k] | re[k];
                al  = (addr[k][2:0] == 3'd0);
                m_mis[k] = m_idle(k, cyc) && req && !al;
                if (m_busy(k, cyc) && cyc == acc_t[k] + LATS[k]) begin
                    if (l_w[k]) mm[k][l_idx[k]] = l_d[k];
                    else        m_rd[k] = mm[k][l_idx[k]];
                end else if (m_idle(k, cyc) && req && al) begin
                    acc_t[k] = cyc;
                    l_idx[k] = addr[k][7:3];
                    l_d[k]   = wdata[k];
                    l_w[k]   = we[k];
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit es;
            es = reset && ((m_idle(k, cyc) && (we[k] | re[k]) && addr[k][2:0] == 3'd0)
                           || m_busy(k, cyc));
            chk($sformatf("model stall[%0d]", k), 64'(stall_o[k]), 64'(es));
            chk($sformatf("model rdata[%0d]", k), rdata[k], m_rd[k]);
            chk($sformatf("model mis[%0d]", k), 64'(mis_o[k]), 64'(m_mis[k]));
        end
    end

    task automatic drive(int k, logic [63:0] a, logic [63:0] d, logic w, logic r);
        addr[k] = a; wdata[k] = d; we[k] = w; re[k] = r;
    endtask

    // Core model: present a request and hold it until stall drops (DONE cycle).
    task automatic access(int k, logic [63:0] a, logic [63:0] d, logic w, logic r,
                          output int nst, output int t0);
        bit fin;
        @(posedge clk); #1;
        drive(k, a, d, w, r);
        t0  = cyc;
        nst = 0;
        fin = 1'b0;
        for (int i = 0; i < 12 && !fin; i++) begin
            @(negedge clk);
            if (stall_o[k] === 1'b1) nst++;
            else fin = 1'b1;
        end
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL stall timeout[%0d]: got stall held expected release", k);
        end
    endtask

    task automatic idle(int k);
        @(posedge clk); #1;
        drive(k, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    int nst, t1, t2;

    initial begin
        m_clear();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rdata", rdata[0], 64'd0);
        chk("reset stall", 64'(stall_o[0]), 64'd0);
        chk("reset mis", 64'(mis_o[0]), 64'd0);
        #2 reset = 1'b1;

        access(0, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, nst, t1);
        chk("write stall len", 64'(nst), 64'd3);
        access(0, 64'h10, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("read stall len", 64'(nst), 64'd3);
        chk("read data", rdata[0], 64'hDEADBEEF_CAFEF00D);

        access(0, 64'h100, 64'h1, 1'b1, 1'b0, nst, t1);
        access(0, 64'h0, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("wrap read", rdata[0], 64'h1);

        access(0, 64'h13, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("misaligned stall len", 64'(nst), 64'd0);
        idle(0);
        @(negedge clk);
        chk("misaligned pulse", 64'(mis_o[0]), 64'd1);
        chk("misaligned rdata", rdata[0], 64'h1);
        @(negedge clk);
        chk("misaligned pulse end", 64'(mis_o[0]), 64'd0);

        access(0, 64'h28, 64'h77, 1'b1, 1'b0, nst, t1);
        access(0, 64'h28, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("preload 0x77", rdata[0], 64'h77);
        access(0, 64'h8, 64'h55, 1'b1, 1'b1, nst, t1);
        chk("both-en stall len", 64'(nst), 64'd3);
        chk("both-en rdata held", rdata[0], 64'h77);
        access(0, 64'h8, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("both-en wrote", rdata[0], 64'h55);

        @(posedge clk); #1;
        drive(0, 64'h18, 64'hAA, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid-reset accept stall", 64'(stall_o[0]), 64'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("mid-reset stall", 64'(stall_o[0]), 64'd0);
        chk("mid-reset rdata", rdata[0], 64'd0);
        @(negedge clk); #2;
        drive(0, 64'd0, 64'd0, 1'b0, 1'b0);
        reset = 1'b1;
        access(0, 64'h18, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("post-reset stall len", 64'(nst), 64'd3);
        chk("post-reset read", rdata[0], 64'd0);
        idle(0);

        access(1, 64'h8, 64'h11, 1'b1, 1'b0, nst, t1);
        access(1, 64'h10, 64'h22, 1'b1, 1'b0, nst, t1);
        access(1, 64'h8, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("lat1 stall len a", 64'(nst), 64'd2);
        chk("lat1 read a", rdata[1], 64'h11);
        access(1, 64'h10, 64'd0, 1'b0, 1'b1, nst, t2);
        chk("lat1 stall len b", 64'(nst), 64'd2);
        chk("lat1 read b", rdata[1], 64'h22);
        chk("lat1 accept gap", 64'(t2 - t1), 64'd3);
        idle(1);

        access(2, 64'h8, 64'h33, 1'b1, 1'b0, nst, t1);
        access(2, 64'h10, 64'h44, 1'b1, 1'b0, nst, t1);
        access(2, 64'h8, 64'd0, 1'b0, 1'b1, nst, t1);
        chk("lat4 stall len a", 64'(nst), 64'd5);
        chk("lat4 read a", rdata[2], 64'h33);
        access(2, 64'h10, 64'd0, 1'b0, 1'b1, nst, t2);
        chk("lat4 stall len b", 64'(nst), 64'd5);
        chk("lat4 read b", rdata[2], 64'h44);
        chk("lat4 accept gap", 64'(t2 - t1), 64'd6);
        idle(2);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
